// File: rtl/sram1rw_req_ctrl_pkg.sv
// Shared types and defaults for the SRAM1RW request front-end.
// State encoding plus default macro geometry.
package sram1rw_req_ctrl_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 20;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram1rw_req_ctrl_if.sv
// Valid/ready request and response bus of the SRAM1RW front-end.
// master = requester side, slave = controller side.
interface sram1rw_req_ctrl_if
  import sram1rw_req_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram1rw_req_ctrl_rsp_fifo.sv
// Small synchronous response FIFO; exports its fill count for credit checks.
// Push and pop may coincide at any fill level.
module sram1rw_req_ctrl_rsp_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/sram1rw_req_ctrl.sv
// Valid/ready front-end for one SRAM1RW macro with a post-reset clear sweep.
// Reads return in order through a credit-guarded response FIFO.
module sram1rw_req_ctrl
  import sram1rw_req_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          DEPTH     = 1 << ADDR_W,
  parameter int          RSP_DEPTH = 2,
  parameter bit          INIT_EN   = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic               CE,
  input  logic               RSTB,
  sram1rw_req_ctrl_if.slave  bus,
  output logic               init_done,
  output logic [ADDR_W-1:0]  sram_a,
  output logic [DATA_W-1:0]  sram_i,
  output logic               sram_csb,
  output logic               sram_web,
  output logic               sram_oeb,
  input  logic [DATA_W-1:0]  sram_o
);

  localparam int CW = $clog2(RSP_DEPTH+1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] init_cnt_nx;
  logic              rd_inflight;
  logic [CW-1:0]     count;
  logic              fire;
  logic              pop;
  logic              credit_ok;

  assign pop  = bus.rsp_valid & bus.rsp_ready;
  assign fire = bus.req_valid & bus.req_ready;

  // Reserve a slot for every read still in the macro pipeline.
  assign credit_ok = (int'(count) + int'(rd_inflight)
                      - int'(pop)) < RSP_DEPTH;

  assign bus.req_ready = RSTB & (state == RUN) & credit_ok;
  assign init_done     = (state == RUN);

  always_ff @(posedge CE) begin
    if (!RSTB) begin
      state       <= INIT_EN ? INIT : RUN;
      init_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else begin
      state       <= state_nx;
      init_cnt    <= init_cnt_nx;
      rd_inflight <= fire & ~bus.req_we;
    end
  end

  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    sram_csb    = 1'b1;
    sram_web    = 1'b1;
    sram_oeb    = 1'b1;
    sram_a      = bus.req_addr;
    sram_i      = bus.req_wdata;
    unique case (state)
      INIT: begin
        sram_csb = 1'b0;
        sram_web = 1'b0;
        sram_a   = init_cnt;
        sram_i   = INIT_VAL;
        if (init_cnt == ADDR_W'(DEPTH-1)) begin
          state_nx = RUN;
        end else begin
          init_cnt_nx = init_cnt + ADDR_W'(1);
        end
      end
      RUN: begin
        sram_csb = ~fire;
        sram_web = ~(fire & bus.req_we);
        sram_oeb = ~(fire & ~bus.req_we);
      end
    endcase
    // No macro access may happen on a reset edge.
    if (!RSTB) begin
      sram_csb = 1'b1;
      sram_web = 1'b1;
      sram_oeb = 1'b1;
    end
  end

  sram1rw_req_ctrl_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (CE),
    .rst_n (RSTB),
    .push  (rd_inflight),
    .wdata (sram_o),
    .pop   (pop),
    .rdata (bus.rsp_rdata),
    .valid (bus.rsp_valid),
    .count (count)
  );

endmodule

// File: tb/tb_sram1rw_req_ctrl.sv
// Directed bench for sram1rw_req_ctrl with a behavioural 64x20 SRAM1RW.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_sram1rw_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic [5:0]  sram_a;
  logic [19:0] sram_i;
  logic        sram_csb;
  logic        sram_web;
  logic        sram_oeb;
  logic [19:0] sram_o;
  logic [19:0] mem [64];

  int checks = 0;
  int errors = 0;

  sram1rw_req_ctrl_if #(.ADDR_W(6), .DATA_W(20)) bus ();

  sram1rw_req_ctrl dut (
    .CE        (clk),
    .RSTB      (rst_n),
    .bus       (bus),
    .init_done (init_done),
    .sram_a    (sram_a),
    .sram_i    (sram_i),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb),
    .sram_o    (sram_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: registered output, write-no-read-through.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else if (!sram_oeb) sram_o <= mem[sram_a];
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic        we,
    input logic [5:0]  adr,
    input logic [19:0] dat
  );
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = adr;
    bus.req_wdata = dat;
    #1;
    chk("req_ready", 32'(bus.req_ready), 1);
    if (we)
      chk("wr_pins", {sram_csb, sram_web, sram_oeb, sram_a, sram_i},
          {3'b001, adr, dat});
    else
      chk("rd_pins", {sram_csb, sram_web, sram_oeb, sram_a},
          {3'b010, adr});
    tick();
    bus.req_valid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int n;
    logic f;
    logic [19:0] held;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // 1. reset, clear sweep, read back a cleared word
    tick();
    tick();
    chk("rst_strobes", {sram_csb, sram_web, sram_oeb}, 3'b111);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_init_done", 32'(init_done), 0);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 64; k++) begin
      chk("sweep_pins",
          {sram_csb, sram_web, sram_oeb, bus.req_ready, init_done, sram_a},
          {5'b00100, 6'(k)});
      chk("sweep_data", sram_i, 0);
      tick();
    end
    chk("init_done", 32'(init_done), 1);
    chk("run_ready", 32'(bus.req_ready), 1);
    chk("run_idle_csb", 32'(sram_csb), 1);
    issue(1'b0, 6'd17, '0);
    chk("rd17_lat1", 32'(bus.rsp_valid), 0);
    tick();
    chk("rd17_valid", 32'(bus.rsp_valid), 1);
    chk("rd17_data", bus.rsp_rdata, 0);
    tick();
    chk("rd17_popped", 32'(bus.rsp_valid), 0);

    // 2. write then immediate read-back
    issue(1'b1, 6'd5, 20'hABCDE);
    issue(1'b0, 6'd5, '0);
    chk("rd5_lat1", 32'(bus.rsp_valid), 0);
    tick();
    chk("rd5_valid", 32'(bus.rsp_valid), 1);
    chk("rd5_data", bus.rsp_rdata, 20'hABCDE);
    tick();

    // 3. back-to-back reads at full throughput
    for (int k = 0; k < 8; k++) issue(1'b1, 6'(k), 20'(k * 3));
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = (c < 8);
      bus.req_we    = 1'b0;
      bus.req_addr  = 6'(c);
      #1;
      if (c < 8) chk("b2b_ready", 32'(bus.req_ready), 1);
      if (c >= 2) begin
        chk("b2b_valid", 32'(bus.rsp_valid), 1);
        chk("b2b_data", bus.rsp_rdata, 20'((c - 2) * 3));
      end
      tick();
    end
    chk("b2b_drained", 32'(bus.rsp_valid), 0);

    // 4. backpressure: only two reads fit
    bus.rsp_ready = 1'b0;
    idx  = 0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 6'(idx + 1);
      #1;
      f = bus.req_ready;
      if (c == 3) held = bus.rsp_rdata;
      tick();
      if (f) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_ready_low", 32'(bus.req_ready), 0);
    chk("bp_valid", 32'(bus.rsp_valid), 1);
    chk("bp_stable", bus.rsp_rdata, held);
    chk("bp_head", bus.rsp_rdata, 20'd3);
    bus.rsp_ready = 1'b1;
    n = 0;
    for (int b = 0; b < 20; b++) begin
      bus.req_valid = (idx < 4);
      bus.req_addr  = 6'(idx + 1);
      #1;
      f = bus.req_valid & bus.req_ready;
      if (bus.rsp_valid) begin
        chk("bp_order", bus.rsp_rdata, 20'((n + 1) * 3));
        n++;
      end
      tick();
      if (f) idx++;
      if (n == 4 && idx == 4) break;
    end
    chk("bp_rsp_count", n, 4);
    chk("bp_req_count", idx, 4);
    bus.req_valid = 1'b0;
    #1;
    chk("bp_no_dup0", 32'(bus.rsp_valid), 0);
    tick();
    chk("bp_no_dup1", 32'(bus.rsp_valid), 0);

    // 5. reset with buffered and in-flight reads
    bus.rsp_ready = 1'b0;
    issue(1'b0, 6'd10, '0);
    issue(1'b0, 6'd11, '0);
    rst_n         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 6'd12;
    #1;
    chk("mid_rst_strobes", {sram_csb, sram_web, sram_oeb}, 3'b111);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    tick();
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_init_done", 32'(init_done), 0);
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("resweep_start", {sram_csb, sram_web, sram_a}, {2'b00, 6'd0});
    for (int k = 0; k < 64; k++) begin
      chk("resweep_no_rsp", {bus.rsp_valid, init_done, sram_a},
          {2'b00, 6'(k)});
      tick();
    end
    chk("resweep_done", 32'(init_done), 1);

    // 6. top address and no wrap-around write
    issue(1'b1, 6'd63, 20'hFFFFF);
    issue(1'b0, 6'd63, '0);
    issue(1'b0, 6'd0, '0);
    chk("rd63_valid", 32'(bus.rsp_valid), 1);
    chk("rd63_data", bus.rsp_rdata, 20'hFFFFF);
    tick();
    chk("rd0_valid", 32'(bus.rsp_valid), 1);
    chk("rd0_data", bus.rsp_rdata, 0);
    tick();
    chk("end_idle", 32'(bus.rsp_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
